fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have one parameter: RESET_PC, default 64'h0, the PC loaded on reset.
REQ-002 The block SHALL have one clock; reset SHALL be asynchronous and active-high.
REQ-003 Ports SHALL be, in order:
- clk  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_req  out  1  instruction-memory request.
- imem_addr  out  64  fetch address; bits [1:0] always 0.
- imem_ack  in  1  single-cycle acknowledge; imem_data is valid in that cycle.
- imem_data  in  32  instruction word.
- stall  in  1  decode cannot accept; the current output is held.
- br_taken  in  1  single-cycle redirect pulse.
- br_base  in  64  PC of the redirecting instruction.
- br_offset  in  64  sign-extended byte offset, already shifted left by 2.
- instr  out  32  instruction presented to decode.
- instr_pc  out  64  address of instr.
- instr_valid  out  1  instr and instr_pc are valid.
- seu_sel  out  2  extender format select, decoded from instr.

Function
REQ-004 The FSM SHALL have three states:
- IDLE: imem_req=0.
- FETCH: imem_req=1 unless the skid buffer is full.
- HOLD: imem_req=0; the skid buffer is full and the output is held.
REQ-005 FSM transitions SHALL be:
- IDLE->FETCH unconditionally after one cycle.
- FETCH->HOLD when imem_ack=1 while instr_valid=1 and stall=1.
- HOLD->FETCH on the cycle the skid buffer moves to the output.
REQ-006 While imem_req=1, imem_addr SHALL stay stable until imem_ack. An ack may arrive in the same cycle as the request.
REQ-007 On imem_ack in FETCH with the output free (instr_valid=0 or stall=0), the block SHALL capture the data as follows:
- instr<=imem_data, instr_pc<=pc, instr_valid<=1.
- pc<=pc+4.
REQ-008 In FETCH, req SHALL remain high, so back-to-back acks give one instruction per cycle.
REQ-009 On imem_ack while the output is held (instr_valid=1, stall=1), the block SHALL:
- write data and pc into a one-entry skid buffer;
- set pc<=pc+4;
- enter HOLD.
REQ-010 In HOLD with stall=0, the skid contents SHALL move to the output in the next cycle, and the skid SHALL become empty.
REQ-011 With stall=0, no ack, and no pending skid, instr_valid SHALL fall to 0 after the consumed instruction. No instruction SHALL be duplicated.
REQ-012 br_taken=1 SHALL have priority over all other events, including a simultaneous ack or stall. It SHALL cause, on the next edge:
- pc<=(br_base+br_offset) with bits [1:0] forced to 0;
- instr_valid<=0 and skid emptied;
- state<=FETCH.
REQ-013 An imem_ack in the same cycle as br_taken SHALL be discarded.
REQ-014 PC arithmetic SHALL be 64-bit, modulo 2^64. pc+4 from 64'hFFFF_FFFF_FFFF_FFFC SHALL wrap to 0.
REQ-015 seu_sel SHALL be combinational from instr:
- opcode[31:26]=000101 or 100101 (B/BL) -> 2'b10.
- [31:24]=10110100, 10110101 or 01010100 (CBZ/CBNZ/B.cond) -> 2'b11.
- [31:21]=11111000010 or 11111000000 (LDUR/STUR) -> 2'b01.
- otherwise -> 2'b00.
REQ-016 An imem_ack while in IDLE SHALL be ignored.

Reset
REQ-017 While reset=1, the block SHALL asynchronously force:
- state=IDLE, pc=RESET_PC, imem_req=0;
- instr=0, instr_pc=0, instr_valid=0, skid empty.
REQ-018 Reset asserted mid-operation, including with an ack pending or the skid full, SHALL discard all in-flight data. The first request after release SHALL use imem_addr=RESET_PC.

Verification
REQ-019 Release reset; ack every cycle with 0x91000421, 0xF8408020 -> imem_addr 0,4,8; instr_pc 0,4; seu_sel 00 then 01; instr_valid continuously 1.
REQ-020 Hold stall=1 with instr_pc=0x4 valid; ack 0x14000010 at addr 0x8 -> imem_req falls; the output still shows pc 0x4. Drop stall -> next cycle instr_pc=0x8, seu_sel=10; fetch resumes at 0xC.
REQ-021 Pulse br_taken with br_base=0x100 and br_offset=0xFFFF_FFFF_FFFF_FFF0, same cycle as an ack -> that ack is dropped; instr_valid=0 next cycle; imem_addr=0xF0.
REQ-022 pc=0xFFFF_FFFF_FFFF_FFFC with an ack -> instr_pc=0xFFFF_FFFF_FFFF_FFFC; next imem_addr=0.
REQ-023 Assert reset while in HOLD with the skid full -> all outputs 0 immediately, without a clock edge. After release: one IDLE cycle, then imem_req=1 at RESET_PC.
REQ-024 Instruction 0xB4000040 (CBZ) -> seu_sel=11; br_taken with stall=1 -> redirect taken; stall ignored for the flush.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing, imem handshake,
// one-entry skid buffer behind a stalled decode, branch redirect.
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [63:0] br_base,
  input  logic [63:0] br_offset,
  output logic [31:0] instr,
  output logic [63:0] instr_pc,
  output logic        instr_valid,
  output logic [1:0]  seu_sel
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [63:0] pc;
  logic [63:0] br_sum;
  logic [63:0] br_tgt;
  logic [31:0] skid_instr;
  logic [63:0] skid_pc;
  logic        skid_valid;
  logic        ack_ok;
  logic        out_busy;

  assign br_sum    = br_base + br_offset;
  assign br_tgt    = {br_sum[63:2], 2'b00};
  assign out_busy  = instr_valid && stall;
  assign ack_ok    = imem_ack && (state == FETCH) && !br_taken;
  assign imem_addr = {pc[63:2], 2'b00};

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state and request; a redirect always lands in FETCH
  always_comb begin
    state_nx = state;
    imem_req = 1'b0;
    unique case (state)
      IDLE: state_nx = FETCH;
      FETCH: begin
        imem_req = !skid_valid;
        if (imem_ack && out_busy) state_nx = HOLD;
      end
      HOLD: if (!stall) state_nx = FETCH;
      default: state_nx = IDLE;
    endcase
    if (br_taken) state_nx = FETCH;
  end

  // PC, output register and skid buffer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= RESET_PC;
      instr       <= 32'h0;
      instr_pc    <= 64'h0;
      instr_valid <= 1'b0;
      skid_instr  <= 32'h0;
      skid_pc     <= 64'h0;
      skid_valid  <= 1'b0;
    end else if (br_taken) begin
      pc          <= br_tgt;
      instr_valid <= 1'b0;
      skid_valid  <= 1'b0;
    end else if (ack_ok) begin
      pc <= pc + 64'd4;
      if (out_busy) begin
        skid_instr <= imem_data;
        skid_pc    <= imem_addr;
        skid_valid <= 1'b1;
      end else begin
        instr       <= imem_data;
        instr_pc    <= imem_addr;
        instr_valid <= 1'b1;
      end
    end else if (!stall) begin
      if (skid_valid) begin
        instr      <= skid_instr;
        instr_pc   <= skid_pc;
        skid_valid <= 1'b0;
      end else begin
        instr_valid <= 1'b0;
      end
    end
  end

  // Immediate-extender format select decoded from the held word
  always_comb begin
    seu_sel = 2'b00;
    unique case (1'b1)
      (instr[31:26] == 6'b000101),
      (instr[31:26] == 6'b100101):        seu_sel = 2'b10;
      (instr[31:24] == 8'b10110100),
      (instr[31:24] == 8'b10110101),
      (instr[31:24] == 8'b01010100):      seu_sel = 2'b11;
      (instr[31:21] == 11'b11111000010),
      (instr[31:21] == 11'b11111000000):  seu_sel = 2'b01;
      default:                            seu_sel = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an expected-instruction
// queue filled on accepted acks and drained on consumption.
module tb_fetch_unit;

  localparam logic [63:0] RPC = 64'h0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_data = 32'h0;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [63:0] br_base = 64'h0;
  logic [63:0] br_offset = 64'h0;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic        instr_valid;
  logic [1:0]  seu_sel;

  typedef struct packed {
    logic [31:0] ins;
    logic [63:0] pc;
  } ent_t;

  ent_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_pc;

  fetch_unit #(.RESET_PC(RPC)) dut (
    .clk(clk),
    .reset(reset),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_data(imem_data),
    .stall(stall),
    .br_taken(br_taken),
    .br_base(br_base),
    .br_offset(br_offset),
    .instr(instr),
    .instr_pc(instr_pc),
    .instr_valid(instr_valid),
    .seu_sel(seu_sel)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [63:0] a);
    case (a)
      64'h0:                   return 32'h91000421;
      64'h4:                   return 32'hF8408020;
      64'h8:                   return 32'h14000010;
      64'hC:                   return 32'hB4000040;
      64'hFFFF_FFFF_FFFF_FFFC: return 32'h94000003;
      default:                 return {8'h8B, a[23:0]};
    endcase
  endfunction

  function automatic logic [1:0] seu_ref(input logic [31:0] i);
    if (i[31:26] == 6'b000101 || i[31:26] == 6'b100101)
      return 2'b10;
    if (i[31:24] == 8'hB4 || i[31:24] == 8'hB5 ||
        i[31:24] == 8'h54)
      return 2'b11;
    if (i[31:21] == 11'b11111000010 ||
        i[31:21] == 11'b11111000000)
      return 2'b01;
    return 2'b00;
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, check consumption, update model
  task automatic cyc(input logic ack,
                     input logic st,
                     input logic br,
                     input logic [63:0] base = 64'h0,
                     input logic [63:0] off = 64'h0);
    ent_t e;
    @(negedge clk);
    imem_ack  = ack;
    stall     = st;
    br_taken  = br;
    br_base   = base;
    br_offset = off;
    imem_data = ack ? imem(imem_addr) : 32'h0;
    if (imem_req) chk("imem_addr", imem_addr, exp_pc);
    if (instr_valid && !st) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL sb_underflow: observed pc %h expected none",
               instr_pc);
      end else begin
        e = sb.pop_front();
        chk("instr", {32'h0, instr}, {32'h0, e.ins});
        chk("instr_pc", instr_pc, e.pc);
        chk("seu_sel", {62'h0, seu_sel}, {62'h0, seu_ref(e.ins)});
      end
    end
    if (br) begin
      sb.delete();
      exp_pc = (base + off) & ~64'h3;
    end else if (ack && imem_req) begin
      e.ins = imem_data;
      e.pc  = imem_addr;
      sb.push_back(e);
      exp_pc = exp_pc + 64'd4;
    end
  endtask

  initial begin
    exp_pc = RPC;

    // reset state
    @(negedge clk);
    chk("rst_req", {63'h0, imem_req}, 64'h0);
    chk("rst_valid", {63'h0, instr_valid}, 64'h0);
    chk("rst_instr", {32'h0, instr}, 64'h0);
    chk("rst_instr_pc", instr_pc, 64'h0);
    chk("rst_addr", imem_addr, RPC);

    // release; ack during IDLE must be ignored
    reset     = 1'b0;
    imem_ack  = 1'b1;
    imem_data = 32'hDEAD_BEEF;
    chk("idle_req", {63'h0, imem_req}, 64'h0);

    // back-to-back fetch
    cyc(1, 0, 0);
    chk("fetch_req", {63'h0, imem_req}, 64'h1);
    cyc(1, 0, 0);
    chk("b2b_valid0", {63'h0, instr_valid}, 64'h1);
    cyc(1, 1, 0);
    chk("b2b_valid1", {63'h0, instr_valid}, 64'h1);
    chk("ldur_seu", {62'h0, seu_sel}, 64'h1);

    // skid full, output held
    cyc(0, 1, 0);
    chk("hold_req", {63'h0, imem_req}, 64'h0);
    chk("hold_pc", instr_pc, 64'h4);
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    chk("skid_pc", instr_pc, 64'h8);
    chk("skid_seu", {62'h0, seu_sel}, 64'h2);

    // CBZ on output; redirect under stall with simultaneous ack
    cyc(1, 1, 1, 64'h100, 64'hFFFF_FFFF_FFFF_FFF0);
    chk("cbz_seu", {62'h0, seu_sel}, 64'h3);
    chk("cbz_pc", instr_pc, 64'hC);
    cyc(1, 0, 0);
    chk("flush_valid", {63'h0, instr_valid}, 64'h0);

    // redirect without stall, ack dropped
    cyc(1, 0, 1, 64'h100, 64'hFFFF_FFFF_FFFF_FFF0);
    cyc(0, 0, 0);
    chk("flush2_valid", {63'h0, instr_valid}, 64'h0);
    chk("flush2_addr", imem_addr, 64'hF0);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("drain_valid", {63'h0, instr_valid}, 64'h0);

    // wrap at top of address space; target low bits masked
    cyc(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFF8, 64'h7);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    chk("wrap_addr", imem_addr, 64'h0);
    cyc(1, 1, 0);
    cyc(0, 1, 0);
    chk("hold2_req", {63'h0, imem_req}, 64'h0);

    // asynchronous reset with skid full
    #2 reset = 1'b1;
    #1;
    chk("arst_req", {63'h0, imem_req}, 64'h0);
    chk("arst_valid", {63'h0, instr_valid}, 64'h0);
    chk("arst_instr", {32'h0, instr}, 64'h0);
    chk("arst_pc", instr_pc, 64'h0);
    chk("arst_seu", {62'h0, seu_sel}, 64'h0);
    chk("arst_addr", imem_addr, RPC);
    sb.delete();
    exp_pc   = RPC;
    imem_ack = 1'b0;
    stall    = 1'b0;

    @(negedge clk);
    reset = 1'b0;
    chk("rel_idle_req", {63'h0, imem_req}, 64'h0);
    cyc(1, 0, 0);
    chk("rel_req", {63'h0, imem_req}, 64'h1);
    chk("rel_addr", imem_addr, RPC);
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("sb_drain", 64'(sb.size()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
